// File: rtl/count_ctrl_pkg.sv
// Shared definitions for the count_ctrl sequencer: FSM states and default sizes.
package count_ctrl_pkg;

   localparam int DEFAULT_WIDTH = 4;
   localparam int DEFAULT_REL_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   // A sequence is in progress while counting or paused
   function automatic logic isBusyState(input state_t s);
      return (s == RUN) || (s == PAUSE);
   endfunction

endpackage

// File: rtl/count_core.sv
// Loadable up/down counter that wraps modulo 2^WIDTH; load has priority over stepping.
module count_core
   import count_ctrl_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             up,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] r_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_q <= '0;
      end else if (load) begin
         r_q <= load_val;
      end else if (en) begin
         r_q <= up ? (r_q + WIDTH'(1)) : (r_q - WIDTH'(1));
      end
   end

   assign q = r_q;

endmodule

// File: rtl/count_ctrl.sv
// Count sequencer: runs count_core from a latched start value toward a latched terminal
// value, with pause/abort, optional auto-reload and a saturating terminal-event counter.
module count_ctrl
   import count_ctrl_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int REL_W = DEFAULT_REL_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             pause,
   input  logic             abort,
   input  logic             up,
   input  logic             auto_reload,
   input  logic [WIDTH-1:0] init_val,
   input  logic [WIDTH-1:0] term_val,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done,
   output logic [REL_W-1:0] term_cnt
);

   state_t           r_state;
   state_t           w_nextState;

   logic             r_up;
   logic             r_autoReload;
   logic [WIDTH-1:0] r_initVal;
   logic [WIDTH-1:0] r_termVal;

   logic             r_busy;
   logic             r_done;
   logic [REL_W-1:0] r_termCnt;

   logic             w_accept;
   logic             w_termEvt;
   logic             w_load;
   logic             w_en;
   logic [WIDTH-1:0] w_loadVal;
   logic [WIDTH-1:0] w_count;

   count_core #(
      .WIDTH(WIDTH)
   ) u_core (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (w_en),
      .load     (w_load),
      .load_val (w_loadVal),
      .up       (r_up),
      .q        (w_count)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Within RUN the order of tests encodes abort > pause > terminal > step
   always_comb begin
      w_nextState = r_state;
      w_accept    = 1'b0;
      w_termEvt   = 1'b0;
      w_load      = 1'b0;
      w_en        = 1'b0;
      w_loadVal   = r_initVal;
      case (r_state)
         IDLE, DONE: begin
            if (abort) begin
               w_nextState = IDLE;
            end else if (start) begin
               w_accept    = 1'b1;
               w_load      = 1'b1;
               w_loadVal   = init_val;
               w_nextState = RUN;
            end
         end
         RUN: begin
            if (abort) begin
               w_nextState = IDLE;
            end else if (pause) begin
               w_nextState = PAUSE;
            end else if (w_count == r_termVal) begin
               w_termEvt = 1'b1;
               if (r_autoReload) begin
                  w_load = 1'b1;
               end else begin
                  w_nextState = DONE;
               end
            end else begin
               w_en = 1'b1;
            end
         end
         PAUSE: begin
            if (abort) begin
               w_nextState = IDLE;
            end else if (!pause) begin
               w_nextState = RUN;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Status outputs, terminal-event tally and the configuration captured at start
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_termCnt    <= '0;
         r_up         <= 1'b0;
         r_autoReload <= 1'b0;
         r_initVal    <= '0;
         r_termVal    <= '0;
      end else begin
         r_busy <= isBusyState(w_nextState);
         r_done <= w_termEvt;
         if (w_accept) begin
            r_termCnt    <= '0;
            r_up         <= up;
            r_autoReload <= auto_reload;
            r_initVal    <= init_val;
            r_termVal    <= term_val;
         end else if (w_termEvt && (r_termCnt != {REL_W{1'b1}})) begin
            r_termCnt <= r_termCnt + REL_W'(1);
         end
      end
   end

   assign count    = w_count;
   assign busy     = r_busy;
   assign done     = r_done;
   assign term_cnt = r_termCnt;

endmodule

// File: tb/tb_count_ctrl.sv
// Scoreboard bench for count_ctrl: a behavioural model predicts every cycle's outputs
// as inputs are driven, and an independent monitor compares them after each edge.
module tb_count_ctrl;

   localparam int W    = 4;
   localparam int RW   = 8;
   localparam int MODV = 1 << W;
   localparam int SATV = (1 << RW) - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          pause = 1'b0;
   logic          abort = 1'b0;
   logic          up = 1'b0;
   logic          auto_reload = 1'b0;
   logic [W-1:0]  init_val = '0;
   logic [W-1:0]  term_val = '0;
   logic [W-1:0]  count;
   logic          busy;
   logic          done;
   logic [RW-1:0] term_cnt;

   typedef struct {
      int cnt;
      int busy;
      int done;
      int tcnt;
   } exp_t;

   exp_t sbq[$];
   int   checkCnt = 0;
   int   passCnt  = 0;

   // Model: "active" covers counting or paused; idle and finished behave identically
   bit   mActive = 1'b0;
   bit   mPaused = 1'b0;
   bit   mUp     = 1'b0;
   bit   mAuto   = 1'b0;
   int   mCount  = 0;
   int   mInit   = 0;
   int   mTerm   = 0;
   int   mTcnt   = 0;

   always #5 clk = ~clk;

   count_ctrl #(
      .WIDTH(W),
      .REL_W(RW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .pause       (pause),
      .abort       (abort),
      .up          (up),
      .auto_reload (auto_reload),
      .init_val    (init_val),
      .term_val    (term_val),
      .count       (count),
      .busy        (busy),
      .done        (done),
      .term_cnt    (term_cnt)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input int exp);
      checkCnt++;
      if (act !== exp) begin
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end else begin
         passCnt++;
      end
   endtask

   // Drive one cycle of inputs and predict the outputs seen after the next rising edge
   task automatic applyStimulus(input bit iRst, input bit iStart, input bit iPause,
                                input bit iAbort, input bit iUp, input bit iAuto,
                                input int iInit, input int iTerm);
      exp_t e;
      bit   d;
      @(negedge clk);
      rst_n       = iRst;
      start       = iStart;
      pause       = iPause;
      abort       = iAbort;
      up          = iUp;
      auto_reload = iAuto;
      init_val    = iInit[W-1:0];
      term_val    = iTerm[W-1:0];
      d = 1'b0;
      if (!iRst) begin
         mActive = 0; mPaused = 0; mCount = 0; mTcnt = 0;
         mUp = 0; mAuto = 0; mInit = 0; mTerm = 0;
      end else if (!mActive) begin
         if (!iAbort && iStart) begin
            mActive = 1; mPaused = 0;
            mCount = iInit % MODV; mTcnt = 0;
            mUp = iUp; mAuto = iAuto; mInit = iInit % MODV; mTerm = iTerm % MODV;
         end
      end else if (iAbort) begin
         mActive = 0; mPaused = 0;
      end else if (mPaused) begin
         if (!iPause) mPaused = 0;
      end else if (iPause) begin
         mPaused = 1;
      end else if (mCount == mTerm) begin
         d = 1'b1;
         mTcnt = (mTcnt < SATV) ? mTcnt + 1 : SATV;
         if (mAuto) mCount = mInit;
         else mActive = 0;
      end else begin
         mCount = mUp ? (mCount + 1) % MODV : (mCount + MODV - 1) % MODV;
      end
      e.cnt  = mCount;
      e.busy = mActive ? 1 : 0;
      e.done = d ? 1 : 0;
      e.tcnt = mTcnt;
      sbq.push_back(e);
   endtask

   // Cycles with no control activity; config inputs carry noise that must be ignored
   task automatic runCycles(input int n, input bit iPause);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b1, 1'b0, iPause, 1'b0, 1'($urandom_range(1)),
                       1'($urandom_range(1)), int'($urandom_range(15)),
                       int'($urandom_range(15)));
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            checkOutput("count", 32'(count), e.cnt);
            checkOutput("busy", 32'(busy), e.busy);
            checkOutput("done", 32'(done), e.done);
            checkOutput("term_cnt", 32'(term_cnt), e.tcnt);
         end
      end
   end

   initial begin : stimulus
      repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 9, 9);
      runCycles(2, 1'b0);

      $display("[TB] one-shot up 2..5");
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2, 5);
      runCycles(6, 1'b0);

      $display("[TB] one-shot down 1..14 with wrap");
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 14);
      runCycles(6, 1'b0);

      $display("[TB] auto-reload 0..3 for 20 cycles");
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0, 3);
      runCycles(20, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);

      $display("[TB] pause held at 4");
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2, 9);
      runCycles(2, 1'b0);
      runCycles(3, 1'b1);
      runCycles(8, 1'b0);

      $display("[TB] abort at 3, start during RUN ignored");
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 9);
      runCycles(1, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12, 13);
      runCycles(1, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
      runCycles(3, 1'b0);

      $display("[TB] start and abort together in IDLE");
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5, 9);
      runCycles(2, 1'b0);

      $display("[TB] reset mid-RUN with start high");
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6, 1);
      runCycles(3, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6, 1);
      runCycles(2, 1'b0);

      $display("[TB] init equals term with auto-reload, saturation");
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 7, 7);
      runCycles(270, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);

      $display("[TB] randomized traffic");
      for (int i = 0; i < 3000; i++) begin
         applyStimulus(1'($urandom_range(99) >= 2), 1'($urandom_range(99) < 20),
                       1'($urandom_range(99) < 12), 1'($urandom_range(99) < 4),
                       1'($urandom_range(1)), 1'($urandom_range(1)),
                       int'($urandom_range(15)), int'($urandom_range(15)));
      end

      for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge clk);
      #2;
      checkCnt++;
      if (sbq.size() != 0) begin
         $display("[TB] FAIL drain: got %0d pending expected 0", sbq.size());
      end else begin
         passCnt++;
      end
      $display("%0d/%0d checks passed", passCnt, checkCnt);
      $finish;
   end

endmodule
